// File: rtl/spi_shift_engine.sv
// SPI master shift engine (mode 0) driven by an external clock divider.
// A request is latched in IDLE, chip select is asserted for one SETUP
// cycle with the first bit on mosi, then the divider runs while miso is
// sampled on each spi_clk rise and mosi advances on each fall. DONE
// publishes the right-aligned received word with a one-cycle rx_valid.
//
// Build option: define SPI_LSB_FIRST_EN for LSB-first shifting; the
// default build shifts MSB-first.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tx_valid/tx_ready transfer request handshake (ready only in IDLE)
//   tx_data, tx_len   right-aligned word and bit count (0 or >max = max)
//   spi_clk           serial clock from the divider, synchronous to clk
//   div_start         divider run request (high throughout XFER)
//   div_n_pulses      latched bit count for the divider
//   cs_n, mosi, miso  serial interface
//   rx_data, rx_valid received word and its one-cycle update strobe
//   busy              high in every state except IDLE
module spi_shift_engine #(
  parameter int SPI_MAXLEN = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [SPI_MAXLEN-1:0]         tx_data,
  input  logic [$clog2(SPI_MAXLEN):0]   tx_len,
  input  logic                          spi_clk,
  output logic                          div_start,
  output logic [$clog2(SPI_MAXLEN):0]   div_n_pulses,
  output logic                          cs_n,
  output logic                          mosi,
  input  logic                          miso,
  output logic [SPI_MAXLEN-1:0]         rx_data,
  output logic                          rx_valid,
  output logic                          busy
);

  localparam int unsigned LW = $clog2(SPI_MAXLEN) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

  state_t                state;
  logic [SPI_MAXLEN-1:0] tx_sh;
  logic [SPI_MAXLEN-1:0] rx_sh;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         bit_cnt;
  logic                  spi_prev;

  logic                  spi_rise_c;
  logic                  spi_fall_c;
  logic [LW-1:0]         len_eff_c;
  logic [SPI_MAXLEN-1:0] tx_load_c;
  logic [SPI_MAXLEN-1:0] tx_next_c;
  logic [SPI_MAXLEN-1:0] rx_shift_c;
  logic [SPI_MAXLEN-1:0] rx_align_c;
  logic                  first_bit_c;
  logic                  next_bit_c;

  // Edge detection against the previous-cycle spi_clk sample
  assign spi_rise_c = spi_clk & ~spi_prev;
  assign spi_fall_c = ~spi_clk & spi_prev;

  // Zero or oversize lengths fall back to a full-width transfer
  assign len_eff_c = ((tx_len == '0) || (tx_len > LW'(SPI_MAXLEN)))
                     ? LW'(SPI_MAXLEN) : tx_len;

`ifdef SPI_LSB_FIRST_EN
  // LSB-first: shift out of bit 0, shift received bits in at the top
  assign tx_load_c   = tx_data;
  assign first_bit_c = tx_load_c[0];
  assign tx_next_c   = {1'b0, tx_sh[SPI_MAXLEN-1:1]};
  assign next_bit_c  = tx_next_c[0];
  assign rx_shift_c  = {miso, rx_sh[SPI_MAXLEN-1:1]};
  assign rx_align_c  = rx_sh >> (LW'(SPI_MAXLEN) - len_q);
`else
  // MSB-first: left-align the word so bit (len-1) leaves first
  assign tx_load_c   = tx_data << (LW'(SPI_MAXLEN) - len_eff_c);
  assign first_bit_c = tx_load_c[SPI_MAXLEN-1];
  assign tx_next_c   = {tx_sh[SPI_MAXLEN-2:0], 1'b0};
  assign next_bit_c  = tx_next_c[SPI_MAXLEN-1];
  assign rx_shift_c  = {rx_sh[SPI_MAXLEN-2:0], miso};
  assign rx_align_c  = rx_sh;
`endif

  // Transfer sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tx_ready     <= 1'b1;
      busy         <= 1'b0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      div_start    <= 1'b0;
      div_n_pulses <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      len_q        <= '0;
      bit_cnt      <= '0;
      spi_prev     <= 1'b0;
    end else begin
      spi_prev <= spi_clk;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cs_n      <= 1'b1;
          mosi      <= 1'b0;
          div_start <= 1'b0;
          if (tx_valid && tx_ready) begin
            state        <= SETUP;
            tx_ready     <= 1'b0;
            busy         <= 1'b1;
            len_q        <= len_eff_c;
            div_n_pulses <= len_eff_c;
            tx_sh        <= tx_load_c;
            rx_sh        <= '0;
            bit_cnt      <= '0;
            cs_n         <= 1'b0;
            mosi         <= first_bit_c;
          end
        end
        SETUP: begin
          state     <= XFER;
          div_start <= 1'b1;
        end
        XFER: begin
          if (spi_rise_c) begin
            // Rises past the programmed length are ignored
            if (bit_cnt < len_q) begin
              rx_sh   <= rx_shift_c;
              bit_cnt <= bit_cnt + LW'(1);
            end
          end else if (spi_fall_c) begin
            if (bit_cnt >= len_q) begin
              state     <= DONE;
              div_start <= 1'b0;
              cs_n      <= 1'b1;
              mosi      <= 1'b0;
              rx_data   <= rx_align_c;
              rx_valid  <= 1'b1;
            end else if (bit_cnt != '0) begin
              // A fall before any rise would skip the first bit
              tx_sh <= tx_next_c;
              mosi  <= next_bit_c;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          tx_ready     <= 1'b1;
          busy         <= 1'b0;
          div_n_pulses <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: a behavioural divider and
// miso source, a negedge monitor collecting per-transfer observations,
// and a reference model computing expected mosi order and rx_data from
// the bit-ordering rules. Honours SPI_LSB_FIRST_EN when defined.
module tb_spi_shift_engine;

  localparam int MAXLEN = 16;
  localparam int LW     = 5;
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              tx_valid;
  logic              tx_ready;
  logic [MAXLEN-1:0] tx_data;
  logic [LW-1:0]     tx_len;
  logic              spi_clk;
  logic              div_start;
  logic [LW-1:0]     div_n_pulses;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [MAXLEN-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  spi_shift_engine #(.SPI_MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_len(tx_len), .spi_clk(spi_clk),
    .div_start(div_start), .div_n_pulses(div_n_pulses), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // miso_mode: 0 random, 1 loopback from mosi, 2 tied high
  int miso_mode = 0;
  int half      = 1;

  // Monitor observations for the current transfer
  bit                mosi_q[$];
  bit                miso_q[$];
  int                rise_cnt;
  int                rxv_cnt;
  int                cs_hi_busy;
  int                viol = 0;
  logic [MAXLEN-1:0] prev_rx;
  logic              prev_sc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [LW-1:0] l);
    return ((l == 0) || (l > MAXLEN)) ? MAXLEN : int'(l);
  endfunction

  // Divider model: toggles spi_clk every 'half' cycles while div_start
  initial begin
    spi_clk = 1'b0;
    forever begin : div_loop
      int hcnt;
      hcnt = 0;
      forever begin
        @(posedge clk);
        #1;
        if (div_start === 1'b1) begin
          hcnt++;
          if (hcnt >= half) begin
            hcnt    = 0;
            spi_clk = ~spi_clk;
            if (!spi_clk && miso_mode == 0) miso = 1'($urandom);
          end
        end else begin
          spi_clk = 1'b0;
          hcnt    = 0;
        end
        if (miso_mode == 1) miso = mosi;
        else if (miso_mode == 2) miso = 1'b1;
      end
    end
  end

  // Monitor: rises, rx_valid pulses, chip-select and idle invariants
  initial begin
    prev_sc = 1'b0;
    prev_rx = '0;
    forever begin
      @(negedge clk);
      if (spi_clk && !prev_sc && !cs_n && busy) begin
        rise_cnt++;
        mosi_q.push_back(mosi);
        miso_q.push_back(miso);
      end
      prev_sc = spi_clk;
      if (rx_valid === 1'b1) rxv_cnt++;
      if (busy === 1'b1 && cs_n === 1'b1) cs_hi_busy++;
      if (!rst) begin
        if (busy === 1'b0 && (cs_n !== 1'b1 || mosi !== 1'b0 ||
                              tx_ready !== 1'b1 || div_start !== 1'b0)) viol++;
        if (busy === 1'b1 && tx_ready !== 1'b0) viol++;
        if (rx_valid !== 1'b1 && rx_data !== prev_rx) viol++;
      end
      prev_rx = rx_data;
    end
  end

  task automatic clear_mon();
    mosi_q.delete();
    miso_q.delete();
    rise_cnt   = 0;
    rxv_cnt    = 0;
    cs_hi_busy = 0;
  endtask

  // Request a transfer and check the SETUP cycle
  task automatic start(input logic [MAXLEN-1:0] d, input logic [LW-1:0] l, input int mode);
    int n;
    tick();
    miso_mode = mode;
    half      = $urandom_range(1, 3);
    miso      = (mode == 2) ? 1'b1 : 1'($urandom);
    clear_mon();
    tx_data  = d;
    tx_len   = l;
    tx_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy !== 1'b1 && n < 10);
    tx_valid = 1'b0;
    check("accept", busy, 1);
    check("div_n_pulses", div_n_pulses, eff_len(l));
    check("setup_cs_n", cs_n, 0);
    check("setup_div_start", div_start, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rxv_cnt == 0 && n < 600) begin
      tick();
      n++;
    end
    check("done_seen", (rxv_cnt != 0) ? 1 : 0, 1);
  endtask

  // Compare observations with the bit-ordering reference
  task automatic check_xfer(input logic [MAXLEN-1:0] d, input int l, input int mode);
    logic [31:0] mo_obs, mo_exp, rx_exp, mask;
    int pos;
    mask   = (32'h1 << l) - 32'h1;
    mo_obs = '0;
    mo_exp = '0;
    rx_exp = '0;
    for (int i = 0; i < mosi_q.size() && i < 32; i++) mo_obs[i] = mosi_q[i];
    for (int i = 0; i < l; i++) begin
      pos       = LSB ? i : (l - 1 - i);
      mo_exp[i] = d[pos];
      if (mode == 0 && i < miso_q.size()) rx_exp[pos] = miso_q[i];
    end
    if (mode == 1) rx_exp = {16'h0, d} & mask;
    if (mode == 2) rx_exp = mask;
    check("rise_count", rise_cnt, l);
    check("mosi_seq", mo_obs, mo_exp);
    check("rx_data", {16'h0, rx_data}, rx_exp);
    check("rx_valid_pulses", rxv_cnt, 1);
    check("cs_n_high_busy", cs_hi_busy, 1);
  endtask

  task automatic run(input logic [MAXLEN-1:0] d, input logic [LW-1:0] l, input int mode);
    start(d, l, mode);
    wait_done();
    tick();
    check_xfer(d, eff_len(l), mode);
  endtask

  initial begin
    logic [MAXLEN-1:0] da, db;
    logic [LW-1:0]     la, lb;
    int n;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_len = '0; miso = 1'b0;
    clear_mon();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_cs_n", cs_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_n", div_n_pulses, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);

    run(16'hA5C3, 5'd16, 1);
    run(16'h00B4, 5'd8, 2);
    run(16'($urandom), 5'd0, 0);
    run(16'($urandom), 5'd20, 1);
    run(16'($urandom), 5'd1, 0);
`ifdef SPI_LSB_FIRST_EN
    run(16'h0001, 5'd4, 1);
`endif
    for (int k = 0; k < 20; k++)
      run(16'($urandom), 5'($urandom_range(0, 31)), $urandom_range(0, 2));

    // Reset in the middle of a transfer
    start(16'h5A5A, 5'd16, 0);
    n = 0;
    while (rise_cnt < 5 && n < 300) begin
      tick();
      n++;
    end
    check("rst_mid_reach5", (rise_cnt >= 5) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    check("abort_cs_n", cs_n, 1);
    check("abort_div_start", div_start, 0);
    check("abort_tx_ready", tx_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_rx_valid", rx_valid, 0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("abort_no_rx_valid", rxv_cnt, 0);

    // Request held across DONE: next transfer starts after one idle cycle
    da = 16'($urandom); la = 5'($urandom_range(1, 16));
    db = 16'($urandom); lb = 5'($urandom_range(0, 31));
    start(da, la, 1);
    tx_data  = db;
    tx_len   = lb;
    tx_valid = 1'b1;
    wait_done();
    check_xfer(da, eff_len(la), 1);
    tick();
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_ready", tx_ready, 1);
    clear_mon();
    tick();
    check("b2b_accept", busy, 1);
    check("b2b_div_n", div_n_pulses, eff_len(lb));
    tx_valid = 1'b0;
    wait_done();
    tick();
    check_xfer(db, eff_len(lb), 1);

    repeat (3) tick();
    check("invariants", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
